// File: rtl/uart_pkg.sv
// Shared UART types: receiver state encoding, parity modes and data-width helpers.
package uart_pkg;

    localparam int unsigned UART_MAX_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } uart_rx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_NONE_ALT = 2'b01,
        PAR_EVEN     = 2'b10,
        PAR_ODD      = 2'b11
    } parity_t;

    // Index of the last data bit for a cfg_bits code (00 -> 4 ... 11 -> 7).
    function automatic logic [2:0] data_last(input logic [1:0] bits);
        return 3'(bits) + 3'd4;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered head, flags and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign rd_nxt  = rd_ptr + AW'(1);

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Head register tracks what mem[rd_ptr] will hold after this cycle's push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            rdata  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_nxt;
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CW'(DEPTH));
            if (do_pop) begin
                if (count > CW'(1)) begin
                    rdata <= mem[rd_nxt];
                end else if (do_push) begin
                    rdata <= wdata;
                end else begin
                    rdata <= '0;
                end
            end else if (do_push && empty) begin
                rdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled bit timing feeding an RX FIFO.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic [DIV_WIDTH-1:0]          cfg_divisor,
    input  logic [1:0]                    cfg_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic                          re,
    output logic [7:0]                    dout,
    output logic                          rx_empty,
    output logic                          rx_full,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int unsigned OS_W     = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_LAST = OVERSAMPLE - 1;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int unsigned START_LAST = OVERSAMPLE / 2;
`else
    localparam int unsigned START_LAST = OVERSAMPLE / 2 - 1;
`endif

    uart_rx_state_t                  state;
    uart_rx_state_t                  state_next;
    parity_t                         par_mode;
    logic                            rx_meta;
    logic                            rx_s;
    logic                            rx_s_d;
    logic [DIV_WIDTH-1:0]            div_cnt;
    logic [OS_W-1:0]                 os_cnt;
    logic [2:0]                      bit_cnt;
    logic [UART_MAX_DATA_BITS-1:0]   shreg;
    logic                            par_bad;
    logic                            stop_bad;
    logic                            tick_c;
    logic                            sample_c;
    logic                            bit_c;
    logic                            has_par_c;
    logic                            last_data_c;
    logic                            push_c;
    logic                            pe_c;
    logic                            fe_c;

    assign par_mode    = parity_t'(cfg_parity);
    assign has_par_c   = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
    assign last_data_c = (bit_cnt >= data_last(cfg_bits));

    // Input synchroniser plus one delayed copy for start-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // Oversample tick generator, held at the reload value while idle.
    assign tick_c = (state != IDLE) && (div_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (state == IDLE || tick_c) begin
            div_cnt <= cfg_divisor;
        end else begin
            div_cnt <= div_cnt - DIV_WIDTH'(1);
        end
    end

    assign sample_c = tick_c && ((state == START) ? (os_cnt == OS_W'(START_LAST))
                                                  : (os_cnt == OS_W'(BIT_LAST)));

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] vote_hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vote_hist <= 2'b11;
        end else if (tick_c) begin
            vote_hist <= {vote_hist[0], rx_s};
        end
    end

    assign bit_c = (vote_hist[1] & vote_hist[0]) | (vote_hist[1] & rx_s) | (vote_hist[0] & rx_s);
`else
    assign bit_c = rx_s;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rx_s_d && !rx_s) state_next = START;
            START:   if (sample_c) state_next = bit_c ? IDLE : DATA;
            DATA:    if (sample_c && last_data_c) state_next = has_par_c ? PARITY : STOP1;
            PARITY:  if (sample_c) state_next = STOP1;
            STOP1:   if (sample_c) state_next = cfg_stop2 ? STOP2 : IDLE;
            STOP2:   if (sample_c) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Push and error flags fire on the sample of the final stop bit.
    always_comb begin
        push_c = 1'b0;
        case (state)
            STOP1:   push_c = sample_c && !cfg_stop2;
            STOP2:   push_c = sample_c;
            default: push_c = 1'b0;
        endcase
        pe_c = push_c && par_bad;
        fe_c = push_c && (stop_bad || !bit_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            os_cnt   <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
        end else if (state == IDLE) begin
            os_cnt   <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
        end else if (tick_c) begin
            os_cnt <= sample_c ? '0 : os_cnt + OS_W'(1);
            if (sample_c) begin
                case (state)
                    DATA: begin
                        shreg[bit_cnt] <= bit_c;
                        bit_cnt        <= bit_cnt + 3'd1;
                    end
                    PARITY:  par_bad  <= (((^shreg) ^ bit_c) != (par_mode == PAR_ODD));
                    STOP1:   stop_bad <= !bit_c;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= pe_c;
            frame_err  <= fe_c;
            overrun    <= push_c && rx_full && !re;
        end
    end

    sync_fifo #(
        .WIDTH (UART_MAX_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .wdata (shreg),
        .pop   (re),
        .rdata (dout),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo against a queue-based frame model.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic [15:0]   cfg_divisor;
    logic [1:0]    cfg_bits;
    logic [1:0]    cfg_parity;
    logic          cfg_stop2;
    logic          re;
    logic [7:0]    dout;
    logic          rx_empty;
    logic          rx_full;
    logic [CW-1:0] rx_count;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;

    int checks  = 0;
    int errors  = 0;
    int pe_seen = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int pe_base, fe_base, ov_base;
    int exp_pe, exp_fe, exp_ov;
    logic [7:0] model_q [$];

    uart_rx_fifo #(
        .OVERSAMPLE (16),
        .FIFO_DEPTH (DEPTH),
        .DIV_WIDTH  (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .cfg_divisor (cfg_divisor),
        .cfg_bits    (cfg_bits),
        .cfg_parity  (cfg_parity),
        .cfg_stop2   (cfg_stop2),
        .re          (re),
        .dout        (dout),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full),
        .rx_count    (rx_count),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse output.
    always @(negedge clk) begin
        if (!reset) begin
            if (parity_err) pe_seen <= pe_seen + 1;
            if (frame_err)  fe_seen <= fe_seen + 1;
            if (overrun)    ov_seen <= ov_seen + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap_zero();
        pe_base = pe_seen;
        fe_base = fe_seen;
        ov_base = ov_seen;
        exp_pe  = 0;
        exp_fe  = 0;
        exp_ov  = 0;
    endtask

    task automatic check_all(input string tag);
        logic [7:0] head;
        head = (model_q.size() > 0) ? model_q[0] : 8'h00;
        check({tag, "_dout"},  32'(dout),     32'(head));
        check({tag, "_count"}, 32'(rx_count), 32'(model_q.size()));
        check({tag, "_empty"}, 32'(rx_empty), 32'(model_q.size() == 0));
        check({tag, "_full"},  32'(rx_full),  32'(model_q.size() == int'(DEPTH)));
        check({tag, "_perr"},  32'(pe_seen - pe_base), 32'(exp_pe));
        check({tag, "_ferr"},  32'(fe_seen - fe_base), 32'(exp_fe));
        check({tag, "_ovr"},   32'(ov_seen - ov_base), 32'(exp_ov));
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop();
        re = 1'b1;
        @(posedge clk);
        #1;
        re = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
    endtask

    // Sends one frame with the current cfg_* settings and updates the model.
    // pop_at_push raises re for exactly the cycle in which the last stop bit is sampled (div=0).
    task automatic send_frame(input logic [7:0] data, input logic bad_par,
                              input logic bad_stop, input logic pop_at_push);
        logic       fbits [$];
        logic [7:0] d;
        logic       pbit;
        int         n;
        int         bit_clks;
        n    = int'(cfg_bits) + 5;
        d    = data & 8'((9'd1 << n) - 9'd1);
        pbit = (^d) ^ cfg_parity[0] ^ bad_par;
        fbits = {};
        fbits.push_back(1'b0);
        for (int i = 0; i < n; i++) fbits.push_back(d[i]);
        if (cfg_parity[1]) fbits.push_back(pbit);
        if (cfg_stop2) fbits.push_back(1'b1);
        fbits.push_back(!bad_stop);

        snap_zero();
        exp_pe = int'(cfg_parity[1] && (((^d) ^ pbit) != cfg_parity[0]));
        exp_fe = int'(bad_stop);
        if (pop_at_push && model_q.size() > 0) void'(model_q.pop_front());
        if (model_q.size() == int'(DEPTH)) exp_ov = 1;
        else model_q.push_back(d);

        bit_clks = 16 * (int'(cfg_divisor) + 1);
        for (int b = 0; b < fbits.size(); b++) begin
            rx = fbits[b];
            for (int c = 0; c < bit_clks; c++) begin
                @(posedge clk);
                #1;
                if (pop_at_push) re = (b == fbits.size() - 1) && (c == 9);
            end
        end
        re = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] bits, input logic [1:0] par, input logic stop2,
                           input logic [15:0] div);
        cfg_bits    = bits;
        cfg_parity  = par;
        cfg_stop2   = stop2;
        cfg_divisor = div;
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        re    = 1'b0;
        set_cfg(2'b11, 2'b00, 1'b0, 16'd0);
        snap_zero();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_dout",  32'(dout),       32'h0);
        check("rst_empty", 32'(rx_empty),   32'h1);
        check("rst_full",  32'(rx_full),    32'h0);
        check("rst_count", 32'(rx_count),   32'h0);
        check("rst_pulse", 32'({parity_err, frame_err, overrun}), 32'h0);

        // 8N1 0xA5
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        idle(4);
        check_all("8n1_a5");
        pop();
        check_all("8n1_pop");

        // 7E2 0x35 with a wrong parity bit
        set_cfg(2'b10, 2'b10, 1'b1, 16'd0);
        send_frame(8'h35, 1'b1, 1'b0, 1'b0);
        idle(4);
        check_all("7e2_bad");
        pop();

        // 5N1 0x1F with stop low, then a 40-bit-time break
        set_cfg(2'b00, 2'b00, 1'b0, 16'd0);
        send_frame(8'h1F, 1'b0, 1'b1, 1'b0);
        check_all("5n1_ferr");
        repeat (40 * 16) @(posedge clk);
        #1;
        idle(40);
        check_all("break");
        pop();

        // Fill with random frames and configurations
        for (int i = 0; i < int'(DEPTH); i++) begin
            set_cfg(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 16'($urandom_range(0, 1)));
            send_frame(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 1'b0);
            idle(4);
            check_all("fill");
        end

        // Ninth frame while full is dropped
        set_cfg(2'b11, 2'b11, 1'b0, 16'd1);
        send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        idle(4);
        check_all("overrun");

        // Frame arriving in the same cycle as a pop is kept
        set_cfg(2'b11, 2'b00, 1'b0, 16'd0);
        send_frame(8'($urandom), 1'b0, 1'b0, 1'b1);
        idle(4);
        check_all("push_pop_full");

        for (int i = 0; i < 5; i++) begin
            pop();
            check_all("drain");
        end

        // False start: 5 clocks low is shorter than half a bit
        snap_zero();
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(40);
        check_all("false_start");
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        idle(4);
        check_all("after_false");
        pop();
        check_all("three_left");

        // Async reset in the middle of a data bit
        rx = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_empty", 32'(rx_empty), 32'h1);
        check("arst_count", 32'(rx_count), 32'h0);
        check("arst_dout",  32'(dout),     32'h0);
        model_q = {};
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(20);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        idle(4);
        check_all("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
